// File: rtl/riscv_pkg.sv
// Shared constants for the RV32I execute/memory slice: opcodes, funct3 names,
// ALU operation codes and next-PC source codes.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_AND    = 4'b0010,
    ALU_OR     = 4'b0011,
    ALU_XOR    = 4'b0100,
    ALU_SLL    = 4'b0101,
    ALU_SRL    = 4'b0110,
    ALU_SRA    = 4'b0111,
    ALU_SLT    = 4'b1000,
    ALU_SLTU   = 4'b1001,
    ALU_PASS_B = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_OFFSET = 2'b01,
    PC_JALR   = 2'b10
  } pc_sel_e;

  // Shared by R-type and I-ALU; 'alt' is funct7[5] already qualified by the caller.
  function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD_SUB: alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     alu_from_f3 = ALU_SLL;
      F3_SLT:     alu_from_f3 = ALU_SLT;
      F3_SLTU:    alu_from_f3 = ALU_SLTU;
      F3_XOR:     alu_from_f3 = ALU_XOR;
      F3_SRL_SRA: alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
      F3_OR:      alu_from_f3 = ALU_OR;
      default:    alu_from_f3 = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/riscv_alu.sv
// 32-bit RV32I ALU: two operands and a 4-bit op code in, result and zero flag out.
module riscv_alu
  import riscv_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [3:0]  op,
  output logic [31:0] result,
  output logic        zero
);

  always_comb begin
    result = 32'd0;
    case (op)
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_AND:    result = a & b;
      ALU_OR:     result = a | b;
      ALU_XOR:    result = a ^ b;
      ALU_SLL:    result = a << b[4:0];
      ALU_SRL:    result = a >> b[4:0];
      ALU_SRA:    result = $signed(a) >>> b[4:0];
      ALU_SLT:    result = {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU:   result = {31'd0, a < b};
      ALU_PASS_B: result = b;
      default:    result = 32'd0;
    endcase
  end

  assign zero = (result == 32'd0);

endmodule

// File: rtl/riscv_exec_core.sv
// Execute/memory slice of the single-cycle RV32I core: decode, ALU, branch
// resolution and a word-addressed data memory with synchronous clear.
module riscv_exec_core
  import riscv_pkg::*;
#(
  parameter int DMEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  output logic        write_reg,
  output logic        read_mem,
  output logic        write_mem,
  output logic        mem_to_reg,
  output logic        src_alu,
  output logic        is_branch,
  output logic        is_jump,
  output logic [3:0]  alu_op,
  output logic [1:0]  pc_select,
  output logic [31:0] alu_result,
  output logic        is_zero,
  output logic [31:0] mem_rdata
);

  localparam int AW = $clog2(DMEM_WORDS);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7_5;
  alu_op_e     op_dec;
  logic        jump_jalr;
  logic [31:0] alu_b;
  logic        branch_taken;
  logic [AW-1:0] mem_idx;
  logic [31:0] mem [DMEM_WORDS];
  logic        unused_bits;

  assign opcode   = instruction[6:0];
  assign funct3   = instruction[14:12];
  assign funct7_5 = instruction[30];

  always_comb begin
    write_reg  = 1'b0;
    read_mem   = 1'b0;
    write_mem  = 1'b0;
    mem_to_reg = 1'b0;
    src_alu    = 1'b0;
    is_branch  = 1'b0;
    is_jump    = 1'b0;
    jump_jalr  = 1'b0;
    op_dec     = ALU_ADD;
    case (opcode)
      OP_R: begin
        write_reg = 1'b1;
        op_dec    = alu_from_f3(funct3, funct7_5);
      end
      // ADDI has no subtract form, so funct7[5] only matters for SRAI.
      OP_I: begin
        write_reg = 1'b1;
        src_alu   = 1'b1;
        op_dec    = alu_from_f3(funct3, funct7_5 && (funct3 == F3_SRL_SRA));
      end
      OP_LOAD: begin
        write_reg  = 1'b1;
        read_mem   = 1'b1;
        mem_to_reg = 1'b1;
        src_alu    = 1'b1;
      end
      OP_STORE: begin
        write_mem = 1'b1;
        src_alu   = 1'b1;
      end
      OP_BRANCH: begin
        is_branch = 1'b1;
        case (funct3)
          F3_BEQ, F3_BNE:   op_dec = ALU_SUB;
          F3_BLT, F3_BGE:   op_dec = ALU_SLT;
          F3_BLTU, F3_BGEU: op_dec = ALU_SLTU;
          default:          op_dec = ALU_ADD;
        endcase
      end
      OP_JAL: begin
        write_reg = 1'b1;
        is_jump   = 1'b1;
      end
      OP_JALR: begin
        write_reg = 1'b1;
        is_jump   = 1'b1;
        src_alu   = 1'b1;
        jump_jalr = 1'b1;
      end
      OP_LUI: begin
        write_reg = 1'b1;
        src_alu   = 1'b1;
        op_dec    = ALU_PASS_B;
      end
      default: ;
    endcase
  end

  assign alu_op = op_dec;
  assign alu_b  = src_alu ? imm : rs2_data;

  riscv_alu u_alu (
    .a      (rs1_data),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result),
    .zero   (is_zero)
  );

  always_comb begin
    branch_taken = 1'b0;
    case (funct3)
      F3_BEQ:           branch_taken = is_zero;
      F3_BNE:           branch_taken = !is_zero;
      F3_BLT, F3_BLTU:  branch_taken = alu_result[0];
      F3_BGE, F3_BGEU:  branch_taken = !alu_result[0];
      default:          branch_taken = 1'b0;
    endcase
  end

  always_comb begin
    pc_select = PC_PLUS4;
    if (jump_jalr)
      pc_select = PC_JALR;
    else if (is_jump || (is_branch && branch_taken))
      pc_select = PC_OFFSET;
  end

  // Byte offset and bits above the array depth are dropped, so addresses wrap.
  assign mem_idx   = alu_result[AW+1:2];
  assign mem_rdata = read_mem ? mem[mem_idx] : 32'd0;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < DMEM_WORDS; i++)
        mem[i] <= 32'd0;
    end else if (write_mem) begin
      mem[mem_idx] <= rs2_data;
    end
  end

  assign unused_bits = ^{instruction[31], instruction[29:15], instruction[11:7],
                         alu_result[31:AW+2], alu_result[1:0]};

endmodule

// File: tb/tb_riscv_exec_core.sv
// Directed bench for riscv_exec_core: decode/ALU/branch vector table plus
// hand-written store, load, wrap and reset sequences for the data memory.
module tb_riscv_exec_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instruction, rs1_data, rs2_data, imm;
  logic        write_reg, read_mem, write_mem, mem_to_reg, src_alu, is_branch, is_jump;
  logic [3:0]  alu_op;
  logic [1:0]  pc_select;
  logic [31:0] alu_result, mem_rdata;
  logic        is_zero;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  riscv_exec_core #(.DMEM_WORDS(256)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instruction (instruction),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .imm         (imm),
    .write_reg   (write_reg),
    .read_mem    (read_mem),
    .write_mem   (write_mem),
    .mem_to_reg  (mem_to_reg),
    .src_alu     (src_alu),
    .is_branch   (is_branch),
    .is_jump     (is_jump),
    .alu_op      (alu_op),
    .pc_select   (pc_select),
    .alu_result  (alu_result),
    .is_zero     (is_zero),
    .mem_rdata   (mem_rdata)
  );

  // flags order: {write_reg, read_mem, write_mem, mem_to_reg, src_alu, is_branch, is_jump}
  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [6:0]  flags;
    logic [3:0]  op;
    logic [1:0]  pc;
    logic [31:0] result;
  } vec_t;

  vec_t vecs[$];

  task automatic applyStimulus(input logic [31:0] i, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] m);
    instruction = i;
    rs1_data    = a;
    rs2_data    = b;
    imm         = m;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  localparam logic [31:0] LW = 32'h00002003;
  localparam logic [31:0] SW = 32'h00002023;

  initial begin
    rst_n = 1'b1;
    applyStimulus(32'h0, 32'h0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;

    vecs.push_back('{"addi",      32'h00500193, 32'h0,        32'h0,        32'h5,   7'b1000100, 4'h0, 2'b00, 32'h5});
    vecs.push_back('{"sub",       32'h40000033, 32'h7,        32'h7,        32'h0,   7'b1000000, 4'h1, 2'b00, 32'h0});
    vecs.push_back('{"sra",       32'h40005033, 32'h80000000, 32'h4,        32'h0,   7'b1000000, 4'h7, 2'b00, 32'hF8000000});
    vecs.push_back('{"slt",       32'h00002033, 32'hFFFFFFFF, 32'h1,        32'h0,   7'b1000000, 4'h8, 2'b00, 32'h1});
    vecs.push_back('{"sltu",      32'h00003033, 32'hFFFFFFFF, 32'h1,        32'h0,   7'b1000000, 4'h9, 2'b00, 32'h0});
    vecs.push_back('{"xor",       32'h00004033, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,   7'b1000000, 4'h4, 2'b00, 32'h0FF00FF0});
    vecs.push_back('{"and",       32'h00007033, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0,   7'b1000000, 4'h2, 2'b00, 32'hF000F000});
    vecs.push_back('{"sll",       32'h00001033, 32'h1,        32'h3F,       32'h0,   7'b1000000, 4'h5, 2'b00, 32'h80000000});
    vecs.push_back('{"srl",       32'h00005033, 32'h80000000, 32'h4,        32'h0,   7'b1000000, 4'h6, 2'b00, 32'h08000000});
    vecs.push_back('{"srai",      32'h40005013, 32'h80000000, 32'h0,        32'h404, 7'b1000100, 4'h7, 2'b00, 32'hF8000000});
    vecs.push_back('{"addi_f7",   32'h40000013, 32'h1,        32'h999,      32'h400, 7'b1000100, 4'h0, 2'b00, 32'h401});
    vecs.push_back('{"lui",       32'h12345037, 32'h55,       32'h0,        32'h12345000, 7'b1000100, 4'hA, 2'b00, 32'h12345000});
    vecs.push_back('{"beq",       32'h00000063, 32'h3,        32'h3,        32'h10,  7'b0000010, 4'h1, 2'b01, 32'h0});
    vecs.push_back('{"bne",       32'h00001063, 32'h3,        32'h3,        32'h10,  7'b0000010, 4'h1, 2'b00, 32'h0});
    vecs.push_back('{"blt",       32'h00004063, 32'hFFFFFFFF, 32'h1,        32'h10,  7'b0000010, 4'h8, 2'b01, 32'h1});
    vecs.push_back('{"bge",       32'h00005063, 32'hFFFFFFFE, 32'h1,        32'h10,  7'b0000010, 4'h8, 2'b00, 32'h1});
    vecs.push_back('{"bltu",      32'h00006063, 32'h1,        32'hFFFFFFFF, 32'h10,  7'b0000010, 4'h9, 2'b01, 32'h1});
    vecs.push_back('{"bgeu",      32'h00007063, 32'h1,        32'hFFFFFFFF, 32'h10,  7'b0000010, 4'h9, 2'b00, 32'h1});
    vecs.push_back('{"jal",       32'h0000006F, 32'h2,        32'h3,        32'h40,  7'b1000001, 4'h0, 2'b01, 32'h5});
    vecs.push_back('{"jalr",      32'h00000067, 32'h100,      32'h7,        32'h8,   7'b1000101, 4'h0, 2'b10, 32'h108});
    vecs.push_back('{"nop",       32'h00000000, 32'h5,        32'h6,        32'h7,   7'b0000000, 4'h0, 2'b00, 32'hB});
    vecs.push_back('{"sw_dec",    SW,           32'h0,        32'h0,        32'h20,  7'b0010100, 4'h0, 2'b00, 32'h20});
    vecs.push_back('{"lw_dec",    LW,           32'h0,        32'h0,        32'h20,  7'b1101100, 4'h0, 2'b00, 32'h20});

    foreach (vecs[k]) begin
      @(negedge clk);
      applyStimulus(vecs[k].instr, vecs[k].rs1, vecs[k].rs2, vecs[k].imm);
      checkOutput({vecs[k].name, ".flags"}, {25'd0, write_reg, read_mem, write_mem, mem_to_reg,
                  src_alu, is_branch, is_jump}, {25'd0, vecs[k].flags});
      checkOutput({vecs[k].name, ".alu_op"}, {28'd0, alu_op}, {28'd0, vecs[k].op});
      checkOutput({vecs[k].name, ".pc_select"}, {30'd0, pc_select}, {30'd0, vecs[k].pc});
      checkOutput({vecs[k].name, ".result"}, alu_result, vecs[k].result);
      checkOutput({vecs[k].name, ".is_zero"}, {31'd0, is_zero}, {31'd0, vecs[k].result == 32'd0});
      checkOutput({vecs[k].name, ".mem_rdata"}, mem_rdata, 32'd0);
    end

    // Store then load, including the same-cycle old value and address wrap.
    @(negedge clk);
    applyStimulus(LW, 32'h0, 32'h0, 32'h8);
    checkOutput("lw_before_store", mem_rdata, 32'h0);
    applyStimulus(SW, 32'h0, 32'hDEADBEEF, 32'h8);
    checkOutput("rdata_during_sw", mem_rdata, 32'h0);
    nextCycle();
    applyStimulus(LW, 32'h0, 32'h0, 32'h8);
    checkOutput("lw_after_store", mem_rdata, 32'hDEADBEEF);
    applyStimulus(LW, 32'h0, 32'h0, 32'h8 + 32'd1024);
    checkOutput("lw_wrap", mem_rdata, 32'hDEADBEEF);
    applyStimulus(LW, 32'h4, 32'h0, 32'h7);
    checkOutput("lw_byte_offset", mem_rdata, 32'hDEADBEEF);
    applyStimulus(LW, 32'h0, 32'h0, 32'hC);
    checkOutput("lw_neighbour", mem_rdata, 32'h0);

    applyStimulus(SW, 32'h20, 32'h12345678, 32'h0);
    nextCycle();
    applyStimulus(LW, 32'h0, 32'h0, 32'h20);
    checkOutput("lw_second", mem_rdata, 32'h12345678);
    applyStimulus(LW, 32'h0, 32'h0, 32'h8);
    checkOutput("lw_first_kept", mem_rdata, 32'hDEADBEEF);

    // Reset together with a store: reset wins and clears earlier writes too.
    applyStimulus(SW, 32'h40, 32'hCAFEF00D, 32'h0);
    rst_n = 1'b1;
    nextCycle();
    rst_n = 1'b0;
    applyStimulus(LW, 32'h0, 32'h0, 32'h40);
    checkOutput("rst_blocks_write", mem_rdata, 32'h0);
    applyStimulus(LW, 32'h0, 32'h0, 32'h8);
    checkOutput("rst_clears_8", mem_rdata, 32'h0);
    applyStimulus(LW, 32'h0, 32'h0, 32'h20);
    checkOutput("rst_clears_20", mem_rdata, 32'h0);

    applyStimulus(SW, 32'h10, 32'hA5A5A5A5, 32'h0);
    nextCycle();
    applyStimulus(LW, 32'h10, 32'h0, 32'h0);
    checkOutput("store_after_rst", mem_rdata, 32'hA5A5A5A5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_exec_core.md
# riscv_exec_core

Execute/memory slice of the single-cycle RV32I core: decodes the fetched instruction into control signals, performs the ALU operation and branch decision, and hosts the word-addressed data memory. It sits between the register file/immediate generator and the write-back mux. Everything is combinational except the data-memory write port and reset.

## Interface
- `DMEM_WORDS`, default 256: data-memory depth in 32-bit words (power of two).
- `clk` in 1: single clock. Memory writes occur on the rising edge.
- `rst_n` in 1: reset. Synchronous, active-high despite the codebase name.
- `instruction` in 32: current instruction.
- `rs1_data` in 32: register-file read port 1.
- `rs2_data` in 32: register-file read port 2; also the store data.
- `imm` in 32: sign-extended immediate from ImmGen.
- `write_reg`, `read_mem`, `write_mem`, `mem_to_reg`, `src_alu`, `is_branch`, `is_jump` out 1: control flags.
- `alu_op` out 4: decoded ALU operation.
- `pc_select` out 2: next-PC source.
  - 00: PC+4.
  - 01: PC+imm (taken branch, JAL).
  - 10: rs1+imm (JALR).
- `alu_result` out 32: ALU output; also the memory address.
- `is_zero` out 1: `alu_result == 0`.
- `mem_rdata` out 32: load data.

## Operation
**ALU encodings.** Operand A = `rs1_data`; operand B = `imm` if `src_alu`, else `rs2_data`.
- 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
- 0101 SLL, 0110 SRL, 0111 SRA. Shift amount is B[4:0].
- 1000 SLT (signed), 1001 SLTU. Result is 32'd0 or 32'd1.
- 1010 PASS_B.
- Any other code gives 0.
- All arithmetic wraps modulo 2^32.

**Decode by opcode.** Unlisted outputs are 0.
- 0110011 (R-type): `write_reg`. `alu_op` from funct3. funct7[5]=1 selects SUB (f3=000) or SRA (f3=101).
- 0010011 (I-ALU): `write_reg`, `src_alu`. ADDI never subtracts. funct7[5] selects SRAI only for f3=101.
- 0000011 (LW): `write_reg`, `read_mem`, `mem_to_reg`, `src_alu`, ADD.
- 0100011 (SW): `write_mem`, `src_alu`, ADD.
- 1100011 (branch): `is_branch`, `src_alu`=0, ALU op chosen by funct3:
  - BEQ/BNE use SUB, taken on `is_zero` / `!is_zero`.
  - BLT/BGE use SLT, taken on `result[0]` / `!result[0]`.
  - BLTU/BGEU use SLTU, with the same taken rule.
  - f3=010/011: never taken.
  - `pc_select`=01 when taken, else 00.
- 1101111 (JAL): `write_reg`, `is_jump`, `pc_select`=01.
- 1100111 (JALR): `write_reg`, `is_jump`, `src_alu`, ADD, `pc_select`=10.
- 0110111 (LUI): `write_reg`, `src_alu`, PASS_B.
- Any other opcode (including all-zero): NOP. All flags 0, `alu_op`=0000, `pc_select`=00.

**Data memory.**
- `DMEM_WORDS` x 32-bit array, indexed by `alu_result[log2(DMEM_WORDS)+1:2]`.
- Byte offset bits [1:0] are ignored. Upper address bits are ignored, so addresses wrap.
- Read is combinational: `mem_rdata` = array word when `read_mem`, else 32'd0.
- Write: on the rising edge with `write_mem` and no reset, the word is written with `rs2_data`.
- Full-word access only.

## Timing
- Control, ALU, `is_zero`, `pc_select` and `mem_rdata`: zero-cycle combinational from inputs.
- Memory write latency: one edge. A read of the same address in the same cycle returns the old word; the following cycle returns the new word.
- Reset: on a rising edge with `rst_n`=1, every memory word is cleared to 0. Reset has priority over a simultaneous write. Reset held for several cycles keeps memory zeroed.
- No other state exists. Combinational outputs are unaffected by reset.
- Reset asserted in the middle of a store sequence discards all prior writes.

## Structure
- Shared package `riscv_pkg`:
  - Opcode constants.
  - funct3 names.
  - 4-bit ALU op codes.
  - 2-bit `pc_select` codes.
- One sub-module, `riscv_alu`: operands, op → result, zero.
- Decode, branch resolution and memory stay inline in `riscv_exec_core`.

## Test plan
- ADDI x3,x0,5 (0x00500193) with `imm`=5, `rs1_data`=0 → `write_reg`=1, `src_alu`=1, `alu_op`=0000, `alu_result`=5.
- SUB (funct7=0100000), rs1=7, rs2=7 → `alu_op`=0001, `alu_result`=0, `is_zero`=1. SRA of 0x80000000 by 4 → 0xF8000000. SLT(-1, 1) → 1. SLTU(-1, 1) → 0.
- SW with rs1=0, imm=8, rs2=0xDEADBEEF, one edge, then LW at the same address → `mem_rdata`=0xDEADBEEF. Address 8+1024 (wrap) → same word. Same-cycle read before the edge → 0.
- BEQ with rs1=rs2=3 → `pc_select`=01. BNE with the same operands → 00. BLTU with rs1=1, rs2=0xFFFFFFFF → 01. BGE with rs1=-2, rs2=1 → 00.
- JAL → `pc_select`=01, `is_jump`=1, `write_reg`=1. JALR → 10. Opcode 0x00 → all flags 0, `pc_select`=00.
- Store nonzero data, assert `rst_n`=1 for one edge together with `write_mem` → the loaded word is 0 at the written address and at every previously written address.
